muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit in the execute stage.
- Consumes the decoder's muldiv_en and 3-bit MulDivFunct. Owns the HI/LO register pair.
- Returns HI/LO reads to the writeback path.
- Asserts stall to freeze the pipeline while a multi-cycle operation blocks an issuing muldiv instruction.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- muldiv_en  input  1  a muldiv instruction is present in execute this cycle
- muldiv_funct  input  3  operation code (encoding below)
- op_a  input  WIDTH  rs value: dividend or multiplicand
- op_b  input  WIDTH  rt value: divisor or multiplier
- busy  output  1  arithmetic operation in progress
- stall  output  1  combinational; upstream must hold the instruction
- result  output  WIDTH  HI or LO read data
- result_valid  output  1  result is meaningful this cycle
- div_zero  output  1  last accepted divide had op_b == 0
- hi_q  output  WIDTH  HI register (debug and forwarding)
- lo_q  output  WIDTH  LO register

Behaviour:
- Reset values: all outputs 0; state IDLE; HI = 0; LO = 0; iteration counter = 0.
- Reset is asynchronous and active-high. Asserting it mid-operation aborts immediately to IDLE with HI/LO cleared.
- muldiv_funct encoding:
  - 000 MULTU, 001 MULT
  - 010 DIVU, 011 DIV
  - 100 MFLO, 101 MFHI
  - 110 MTLO, 111 MTHI
- Acceptance: an instruction is accepted on a rising edge where muldiv_en = 1 and stall = 0.
- stall = muldiv_en & busy, for every funct. A MT or MF while busy waits; nothing is queued.
- MF (100, 101) when idle:
  - result = LO (100) or HI (101), combinational, same cycle.
  - result_valid = muldiv_en & ~stall & funct[2] & ~funct[1].
  - Otherwise result = 0.
- MT (110, 111) when idle: op_a is written to LO or HI at the accepting edge. No busy cycles.
- Arithmetic accept (funct[2] = 0):
  - Capture the operand magnitudes. For signed ops (funct[0] = 1) take two's-complement absolute values and latch sign flags.
  - Latch div_zero = funct[1] & (op_b == 0). div_zero holds until the next arithmetic accept.
  - Next state is MUL or DIV; busy = 1 from the following cycle.
- State machine: IDLE -> MUL | DIV -> FIX -> IDLE.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles. Builds a 2*WIDTH-bit product.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles. WIDTH+1-bit partial remainder.
  - FIX: one cycle.
    - MULT: negate the 2*WIDTH product if signA ^ signB.
    - DIV: negate the quotient if signA ^ signB; the remainder takes the sign of the dividend.
    - Write HI = product[2W-1:W] / remainder and LO = product[W-1:0] / quotient.
- Latency: busy is high for exactly WIDTH+1 cycles after the accepting edge. HI/LO are updated at the FIX edge, and busy is 0 in the following cycle.
- Divide by zero: full latency still applies. Forced results are LO = all ones, HI = op_a as originally presented (signed or unsigned).
- Signed overflow: most-negative / -1 gives LO = most-negative, HI = 0, with no flag.
- Operands are sampled only at accept. op_a/op_b changes while busy have no effect.
- Counter: counts 0..WIDTH-1 in MUL/DIV; wraps to 0 on entering FIX.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the full 2*WIDTH product with a single-cycle multiplier.
  - HI/LO are written at the accepting edge; busy never asserts for multiply.
  - DIV behaviour is unchanged.
- Undefined: multiply uses the iterative MUL path (WIDTH+1 busy cycles).

Test Plan:
- MULTU op_a=FFFFFFFF, op_b=FFFFFFFF -> busy high 33 cycles, then HI=FFFFFFFE, LO=00000001. With MULDIV_FAST_MUL_EN: same values the next cycle, busy never 1.
- MULT op_a=FFFFFFFD (-3), op_b=00000005 -> HI=FFFFFFFF, LO=FFFFFFF1.
- DIV op_a=FFFFFFF9 (-7), op_b=00000002 -> LO=FFFFFFFD (-3), HI=FFFFFFFF (-1), div_zero=0.
- DIVU op_a=0000000A, op_b=0 -> after 33 cycles LO=FFFFFFFF, HI=0000000A, div_zero=1. Then MULTU 2*3 -> div_zero=0, LO=00000006.
- DIVU 100/7 issued, then MFLO held with muldiv_en=1 -> stall=1 for the remaining busy cycles. The first cycle with busy=0 gives stall=0, result=0000000E, result_valid=1. MFHI then gives 00000002.
- MTHI op_a=12345678 when idle -> HI=12345678 next cycle. Start DIV, assert reset at busy cycle 10 -> busy=0, HI=LO=0 immediately, state IDLE.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair (shift-add MUL, restoring DIV).
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             muldiv_en,
  input  logic [2:0]       muldiv_funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             dz_q, dz_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic             accept;
  logic             rd_en;
  logic             cnt_last;
  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0] fix_quo, fix_rem;

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] s;
    s = v;
    return (sgn && s[WIDTH-1]) ? WIDTH'(-s) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign busy         = (state_q != IDLE);
  assign stall        = muldiv_en & busy;
  assign accept       = muldiv_en & ~stall;
  assign rd_en        = accept & muldiv_funct[2] & ~muldiv_funct[1];
  assign result_valid = rd_en;
  assign result       = rd_en ? (muldiv_funct[0] ? hi_q : lo_q) : '0;
  assign div_zero     = dz_q;
  assign cnt_last     = (cnt_q == CW'(WIDTH - 1));

  assign in_sign_a = muldiv_funct[0] & op_a[WIDTH-1];
  assign in_sign_b = muldiv_funct[0] & op_b[WIDTH-1];
  assign mag_a     = abs_w(op_a, muldiv_funct[0]);
  assign mag_b     = abs_w(op_b, muldiv_funct[0]);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag;
  assign fast_mag = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  // Per-iteration datapath and sign fix-up, shared by the FSM below
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    fix_prod  = neg_2w({work_hi_q, work_lo_q}, sign_a_q ^ sign_b_q);
    fix_quo   = dz_q ? '1 : neg_w(work_lo_q, sign_a_q ^ sign_b_q);
    fix_rem   = neg_w(work_hi_q, sign_a_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    is_div_d  = is_div_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!muldiv_funct[2]) begin
            // DIV keeps the dividend in work_lo so quotient bits shift in behind it
            dz_d      = muldiv_funct[1] & (op_b == '0);
            sign_a_d  = in_sign_a;
            sign_b_d  = in_sign_b;
            is_div_d  = muldiv_funct[1];
            work_hi_d = '0;
            work_lo_d = muldiv_funct[1] ? mag_a : mag_b;
            opnd_d    = muldiv_funct[1] ? mag_b : mag_a;
            cnt_d     = '0;
            state_d   = muldiv_funct[1] ? DIV : MUL;
`ifdef MULDIV_FAST_MUL_EN
            if (!muldiv_funct[1]) begin
              {hi_d, lo_d} = neg_2w(fast_mag, in_sign_a ^ in_sign_b);
              state_d      = IDLE;
            end
`endif
          end else if (muldiv_funct[1]) begin
            if (muldiv_funct[0]) hi_d = op_a;
            else                 lo_d = op_a;
          end
        end
      end
      MUL: begin
        work_hi_d = mul_sum[WIDTH:1];
        work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CW'(1);
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      DIV: begin
        if (!div_trial[WIDTH]) begin
          work_hi_d = div_trial[WIDTH-1:0];
          work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          work_hi_d = div_shift[WIDTH-1:0];
          work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (is_div_q) begin
          hi_d = fix_rem;
          lo_d = fix_quo;
        end else begin
          {hi_d, lo_d} = fix_prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      is_div_q  <= 1'b0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      is_div_q  <= is_div_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
    end
  end

endmodule
